// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter
//   Shares one RISC-V DMI request/response channel between two debug requesters
//   (s0 = JTAG DR-shift side, s1 = secondary debug host). Round-robin grant, a single
//   outstanding transaction, and the response is routed back to the requester that owns it.
//   If the DMI does not answer within TMO_CYCLES, a failed-status word is returned instead,
//   so no requester can hang.
//
// Ports
//   clk, dev_rst_n              clock (rising edge), synchronous active-low reset
//   sN_req_vld/rdy/data         request from requester N (N = 0, 1)
//   sN_resp_vld/rdy/data        response to requester N
//   m_req_vld/rdy/data          request toward the DMI
//   m_resp_vld/rdy/data         response from the DMI
//   busy                        a transaction is in flight
//   owner                       index of the requester owning the transaction
//   tmo_evt                     one-cycle pulse when a response timeout was taken
module dmi_req_arbiter #(
  parameter int unsigned DMI_ADDR_WIDTH = 7,
  parameter int unsigned DMI_DATA_WIDTH = 32,
  parameter int unsigned DMI_OP_WIDTH   = 2,
  parameter int unsigned TX_WIDTH       = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH,
  parameter int unsigned RX_WIDTH       = DMI_DATA_WIDTH + DMI_OP_WIDTH,
  parameter int unsigned TMO_CYCLES     = 1023,
  parameter int unsigned TMO_WIDTH      = 10
) (
  input  logic                clk,
  input  logic                dev_rst_n,
  // requester 0
  input  logic                s0_req_vld,
  output logic                s0_req_rdy,
  input  logic [TX_WIDTH-1:0] s0_req_data,
  output logic                s0_resp_vld,
  input  logic                s0_resp_rdy,
  output logic [RX_WIDTH-1:0] s0_resp_data,
  // requester 1
  input  logic                s1_req_vld,
  output logic                s1_req_rdy,
  input  logic [TX_WIDTH-1:0] s1_req_data,
  output logic                s1_resp_vld,
  input  logic                s1_resp_rdy,
  output logic [RX_WIDTH-1:0] s1_resp_data,
  // DMI side
  output logic                m_req_vld,
  input  logic                m_req_rdy,
  output logic [TX_WIDTH-1:0] m_req_data,
  input  logic                m_resp_vld,
  output logic                m_resp_rdy,
  input  logic [RX_WIDTH-1:0] m_resp_data,
  // status
  output logic                busy,
  output logic                owner,
  output logic                tmo_evt
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDlv} state_e;

  localparam bit                   TmoEn   = (TMO_CYCLES != 0);
  localparam logic [TMO_WIDTH-1:0] TmoLast = TMO_WIDTH'(TMO_CYCLES - 1);
  // Failed-status response: zero data, op = 2 (DMI "failed").
  localparam logic [RX_WIDTH-1:0]  TmoWord = {DMI_DATA_WIDTH'(0), DMI_OP_WIDTH'(2)};

  state_e                r_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic                  r_tmo_evt;
  logic [TX_WIDTH-1:0]   r_req_data;
  logic [RX_WIDTH-1:0]   r_resp_data;
  logic [TMO_WIDTH-1:0]  r_tmo_cnt;

  logic w_idle;
  logic w_any_vld;
  logic w_grant;
  logic w_owner_rdy;
  logic w_tmo_hit;

  assign w_idle    = (r_state == StIdle);
  assign w_any_vld = s0_req_vld | s1_req_vld;
  // Contention goes to the requester that did not win last; otherwise the lone valid wins.
  assign w_grant   = (s0_req_vld & s1_req_vld) ? ~r_last_grant : s1_req_vld;
  assign w_owner_rdy = r_owner ? s1_resp_rdy : s0_resp_rdy;
  assign w_tmo_hit   = TmoEn && (r_tmo_cnt == TmoLast);

  always_ff @(posedge clk) begin
    if (!dev_rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_tmo_evt    <= 1'b0;
      r_req_data   <= '0;
      r_resp_data  <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      r_tmo_evt <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_vld) begin
            r_req_data   <= w_grant ? s1_req_data : s0_req_data;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= StReq;
          end
        end
        StReq: begin
          if (m_req_rdy) begin
            r_tmo_cnt <= '0;
            r_state   <= StResp;
          end
        end
        StResp: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_WIDTH'(1);
          // A real response beats a timeout landing on the same cycle.
          if (m_resp_vld) begin
            r_resp_data <= m_resp_data;
            r_state     <= StDlv;
          end else if (w_tmo_hit) begin
            r_resp_data <= TmoWord;
            r_tmo_evt   <= 1'b1;
            r_state     <= StDlv;
          end
        end
        StDlv: begin
          if (w_owner_rdy) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s0_req_rdy   = w_idle & w_any_vld & ~w_grant;
  assign s1_req_rdy   = w_idle & w_any_vld & w_grant;

  assign m_req_vld    = (r_state == StReq);
  assign m_req_data   = r_req_data;
  // Always ready: outside RESP any DMI response is stale and is simply drained.
  assign m_resp_rdy   = 1'b1;

  assign s0_resp_vld  = (r_state == StDlv) & ~r_owner;
  assign s1_resp_vld  = (r_state == StDlv) & r_owner;
  assign s0_resp_data = r_resp_data;
  assign s1_resp_data = r_resp_data;

  assign busy         = ~w_idle;
  assign owner        = r_owner;
  assign tmo_evt      = r_tmo_evt;

endmodule
